// File: rtl/bcd_counter_n.sv
// N-digit cascaded BCD counter: up/down, validated parallel load,
// wrap or saturate at terminal count, sticky overflow.
module bcd_counter_n #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  output logic [4*DIGITS-1:0]   count,
  output logic                  cout,
  output logic                  ovf,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;
  logic         lerr_q, lerr_d;

  logic [W-1:0] inc_v, dec_v;
  logic         all9, all0, din_ok, term;

  always_comb begin : ripple
    logic       c;
    logic       b;
    logic [3:0] dig;
    inc_v  = count_q;
    dec_v  = count_q;
    all9   = 1'b1;
    all0   = 1'b1;
    din_ok = 1'b1;
    c      = 1'b1;
    b      = 1'b1;
    dig    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      if (dig != 4'd9) all9 = 1'b0;
      if (dig != 4'd0) all0 = 1'b0;
      if (c) begin
        if (dig == 4'd9) begin
          inc_v[4*i +: 4] = 4'd0;
        end else begin
          inc_v[4*i +: 4] = dig + 4'd1;
          c = 1'b0;
        end
      end
      if (b) begin
        if (dig == 4'd0) begin
          dec_v[4*i +: 4] = 4'd9;
        end else begin
          dec_v[4*i +: 4] = dig - 4'd1;
          b = 1'b0;
        end
      end
      if (din[4*i +: 4] > 4'd9) din_ok = 1'b0;
    end
  end

  assign term = up ? all9 : all0;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    lerr_d  = 1'b0;
    if (load) begin
      if (din_ok) begin
        count_d = din;
        ovf_d   = 1'b0;
      end else begin
        lerr_d  = 1'b1;
      end
    end else if (en) begin
      // the ripple already yields all-0s / all-9s at terminal count
      if (term) begin
        ovf_d = 1'b1;
        if (WRAP) count_d = up ? inc_v : dec_v;
      end else begin
        count_d = up ? inc_v : dec_v;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      lerr_q  <= lerr_d;
    end
  end

  assign count    = count_q;
  assign ovf      = ovf_q;
  assign load_err = lerr_q;
  assign cout     = en & ~load & term;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench: 2-digit wrap and saturate instances plus
// two cascaded single-digit instances.
module tb_bcd_counter_n;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic       a_en, a_up, a_ld;
  logic [7:0] a_din, a_cnt;
  logic       a_co, a_ovf, a_err;

  logic       b_en, b_up, b_ld;
  logic [7:0] b_din, b_cnt;
  logic       b_co, b_ovf, b_err;

  logic       ce;
  logic [3:0] c0_cnt, c1_cnt;
  logic       c0_co, c0_ovf, c0_err;
  logic       c1_co, c1_ovf, c1_err;

  bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) u_a (
    .clk(clk), .clr(clr), .en(a_en), .up(a_up), .load(a_ld),
    .din(a_din), .count(a_cnt), .cout(a_co), .ovf(a_ovf),
    .load_err(a_err)
  );

  bcd_counter_n #(.DIGITS(2), .WRAP(1'b0)) u_b (
    .clk(clk), .clr(clr), .en(b_en), .up(b_up), .load(b_ld),
    .din(b_din), .count(b_cnt), .cout(b_co), .ovf(b_ovf),
    .load_err(b_err)
  );

  bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) u_c0 (
    .clk(clk), .clr(clr), .en(ce), .up(1'b1), .load(1'b0),
    .din(4'd0), .count(c0_cnt), .cout(c0_co), .ovf(c0_ovf),
    .load_err(c0_err)
  );

  bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) u_c1 (
    .clk(clk), .clr(clr), .en(c0_co), .up(1'b1), .load(1'b0),
    .din(4'd0), .count(c1_cnt), .cout(c1_co), .ovf(c1_ovf),
    .load_err(c1_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] bcd(input int v);
    bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_en = 0; a_up = 1; a_ld = 0; a_din = '0;
    b_en = 0; b_up = 1; b_ld = 0; b_din = '0;
    ce = 0;

    // reset
    #2 clr = 1'b1;
    #6;
    chk("rst_cnt", a_cnt, 8'h00);
    chk("rst_ovf", a_ovf, 1'b0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_b", b_cnt, 8'h00);
    @(negedge clk);
    clr = 1'b0;
    step();

    // count up 00..99 then wrap
    a_en = 1; a_up = 1;
    for (int i = 0; i < 100; i++) begin
      chk("up_cnt", a_cnt, bcd(i));
      chk("up_cout", a_co, (i == 99));
      chk("up_ovf", a_ovf, 1'b0);
      step();
    end
    chk("wrap_cnt", a_cnt, 8'h00);
    chk("wrap_ovf", a_ovf, 1'b1);

    // load 10 then count down 11 edges
    a_en = 0; a_ld = 1; a_din = 8'h10;
    step();
    a_ld = 0;
    chk("ld10_cnt", a_cnt, 8'h10);
    chk("ld10_ovf", a_ovf, 1'b0);
    a_en = 1; a_up = 0;
    for (int k = 0; k < 11; k++) begin
      chk("dn_cnt", a_cnt, bcd(10 - k));
      chk("dn_cout", a_co, (k == 10));
      chk("dn_ovf", a_ovf, 1'b0);
      step();
    end
    chk("dn_wrap", a_cnt, 8'h99);
    chk("dn_ovf1", a_ovf, 1'b1);
    a_en = 0;

    // saturate instance
    b_ld = 1; b_din = 8'h98;
    step();
    b_ld = 0; b_en = 1; b_up = 1;
    chk("sat_98", b_cnt, 8'h98);
    chk("sat_co0", b_co, 1'b0);
    step();
    chk("sat_c1", b_cnt, 8'h99);
    chk("sat_co1", b_co, 1'b1);
    chk("sat_ov0", b_ovf, 1'b0);
    step();
    chk("sat_c2", b_cnt, 8'h99);
    chk("sat_ov1", b_ovf, 1'b1);
    step();
    chk("sat_c3", b_cnt, 8'h99);
    chk("sat_co3", b_co, 1'b1);
    chk("sat_ov3", b_ovf, 1'b1);
    chk("sat_err", b_err, 1'b0);
    b_en = 0;

    // invalid load 3A on A (count 99, ovf 1)
    a_ld = 1; a_din = 8'h3A;
    step();
    a_ld = 0;
    chk("bad_cnt", a_cnt, 8'h99);
    chk("bad_err", a_err, 1'b1);
    chk("bad_ovf", a_ovf, 1'b1);
    step();
    chk("bad_err0", a_err, 1'b0);
    a_ld = 1; a_din = 8'h42;
    step();
    a_ld = 0;
    chk("ld42_cnt", a_cnt, 8'h42);
    chk("ld42_ovf", a_ovf, 1'b0);
    chk("ld42_err", a_err, 1'b0);

    // invalid load with en high: no step either
    a_ld = 1; a_en = 1; a_up = 1; a_din = 8'hA0;
    step();
    chk("bade_cnt", a_cnt, 8'h42);
    chk("bade_err", a_err, 1'b1);

    // load + en at terminal count: load wins, cout low
    a_en = 0; a_din = 8'h99;
    step();
    a_en = 1; a_din = 8'h55;
    #1;
    chk("ldw_cout", a_co, 1'b0);
    step();
    a_ld = 0;
    chk("ldw_cnt", a_cnt, 8'h55);
    step();
    step();
    chk("run_cnt", a_cnt, 8'h57);

    // asynchronous clear mid-cycle
    #2 clr = 1'b1;
    #1;
    chk("aclr_cnt", a_cnt, 8'h00);
    chk("aclr_ovf", a_ovf, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    step();
    chk("post_clr", a_cnt, 8'h01);
    a_en = 0;

    // cascade of two single digits
    ce = 1;
    for (int i = 0; i < 25; i++) step();
    ce = 0;
    chk("casc", {c1_cnt, c0_cnt}, 8'h25);
    chk("casc_ovf", c0_ovf, 1'b1);
    chk("casc_co1", c1_co, 1'b0);
    chk("casc_err", c0_err | c1_err | c1_ovf, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
